// File: rtl/frequency_capture_sequencer.sv
// Capture-cycle controller for the frequency analyzers.
// Runs clear -> run -> latch, then copies every analyzer result into the
// AXI register file, one handshaken write per word, followed by a status
// word. Finishes with a fixed-width irq pulse. All outputs are decoded from
// the asynchronously reset state, so a reset forces them to their idle
// values without waiting for a clock edge.
module frequency_capture_sequencer #(
  parameter int NUMBER_OF_RESULTS = 6,
  parameter int REGISTER_BASE     = 1,
  parameter int CLEAR_CYCLES      = 4,
  parameter int MAX_RUN_CYCLES    = 0,
  parameter int IRQ_PULSE_CYCLES  = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic                              start,
  input  logic                              stop,
  input  logic [32*NUMBER_OF_RESULTS-1:0]   results,
  output logic                              analyzer_enable,
  output logic                              analyzer_clear_n,
  output logic [1:0]                        register_operation,
  output logic [7:0]                        register_number,
  output logic [31:0]                       register_write,
  input  logic                              register_ack,
  output logic                              busy,
  output logic                              irq,
  output logic                              timeout_flag
);

  // Index runs 0..NUMBER_OF_RESULTS; the last value selects the status word.
  localparam int              IDX_W      = $clog2(NUMBER_OF_RESULTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUMBER_OF_RESULTS);
  localparam logic [7:0]      CLEAR_LAST = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0]      IRQ_LAST   = 8'(IRQ_PULSE_CYCLES - 1);
  localparam logic [30:0]     RUN_LAST   = 31'(MAX_RUN_CYCLES - 1);
  localparam logic [30:0]     RUN_SAT    = 31'h7FFF_FFFF;
  localparam logic [7:0]      BASE8      = 8'(REGISTER_BASE);
  localparam logic [1:0]      OP_NONE    = 2'd0;
  localparam logic [1:0]      OP_WRITE   = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    LATCH = 3'd3,
    WRITE = 3'd4,
    IRQ   = 3'd5
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              start_d_reg;
  logic              stop_d_reg;
  logic              start_rise;
  logic              stop_rise;
  logic [7:0]        clr_cnt_reg;
  logic [7:0]        irq_cnt_reg;
  logic [30:0]       run_cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              timeout_reg;
  logic              timeout_hit;
  logic [31:0]       shadow_reg [NUMBER_OF_RESULTS];
  logic [31:0]       shadow_word;
  logic [31:0]       status_word;

  assign start_rise  = start & ~start_d_reg;
  assign stop_rise   = stop & ~stop_d_reg;
  assign timeout_hit = (MAX_RUN_CYCLES != 0) && (run_cnt_reg == RUN_LAST);
  assign status_word = {timeout_reg, run_cnt_reg};
  assign timeout_flag = timeout_reg;

  // State register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Delayed copies of the trigger lines for rising-edge detection.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      start_d_reg <= 1'b0;
      stop_d_reg  <= 1'b0;
    end else begin
      start_d_reg <= start;
      stop_d_reg  <= stop;
    end
  end

  // Phase counters: clear length, run length, irq width and write index.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      clr_cnt_reg <= 8'd0;
      irq_cnt_reg <= 8'd0;
      run_cnt_reg <= 31'd0;
      idx_reg     <= '0;
    end else begin
      clr_cnt_reg <= (state_reg == CLEAR) ? clr_cnt_reg + 8'd1 : 8'd0;
      irq_cnt_reg <= (state_reg == IRQ) ? irq_cnt_reg + 8'd1 : 8'd0;
      // The run count must survive LATCH/WRITE for the status word, so it is
      // only restarted while the analyzers are being cleared.
      if (state_reg == CLEAR) begin
        run_cnt_reg <= 31'd0;
      end else if ((state_reg == RUN) && (run_cnt_reg != RUN_SAT)) begin
        run_cnt_reg <= run_cnt_reg + 31'd1;
      end
      if (state_reg == LATCH) begin
        idx_reg <= '0;
      end else if ((state_reg == WRITE) && register_ack && (idx_reg != LAST_IDX)) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  // Sticky timeout flag: cleared by a new capture, set when the run times
  // out without a simultaneous stop edge.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      timeout_reg <= 1'b0;
    end else if ((state_reg == IDLE) && start_rise) begin
      timeout_reg <= 1'b0;
    end else if ((state_reg == RUN) && !stop_rise && timeout_hit) begin
      timeout_reg <= 1'b1;
    end
  end

  // Snapshot of the analyzer outputs taken in LATCH; later changes on
  // results must not leak into the writes.
  always_ff @(posedge s00_axi_aclk) begin
    if (state_reg == LATCH) begin
      for (int i = 0; i < NUMBER_OF_RESULTS; i++) begin
        shadow_reg[i] <= results[32*i +: 32];
      end
    end
  end

  // Select the shadow word for the current write index.
  always_comb begin
    shadow_word = 32'd0;
    for (int i = 0; i < NUMBER_OF_RESULTS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        shadow_word = shadow_reg[i];
      end
    end
  end

  // Next-state logic and output decode.
  always_comb begin
    state_next         = state_reg;
    analyzer_enable    = 1'b0;
    analyzer_clear_n   = 1'b1;
    register_operation = OP_NONE;
    register_number    = 8'd0;
    register_write     = 32'd0;
    busy               = 1'b1;
    irq                = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        // A stop edge alone is ignored; with both edges, start wins.
        if (start_rise) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        analyzer_clear_n = 1'b0;
        if (stop_rise) begin
          state_next = IDLE;
        end else if (clr_cnt_reg == CLEAR_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        analyzer_enable = 1'b1;
        if (stop_rise || timeout_hit) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        state_next = WRITE;
      end
      WRITE: begin
        register_operation = OP_WRITE;
        register_number    = BASE8 + 8'(idx_reg);
        register_write     = (idx_reg == LAST_IDX) ? status_word : shadow_word;
        if (register_ack && (idx_reg == LAST_IDX)) begin
          state_next = IRQ;
        end
      end
      IRQ: begin
        irq = 1'b1;
        if (irq_cnt_reg == IRQ_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
